branch_redirect_unit: RTL
=========================

BRANCH_REDIRECT_UNIT -- requirements
Module: branch_redirect_unit

Interface
REQ-001 The block SHALL provide parameter PC_W, default 9, the width of every program counter and target bus.
REQ-002 The block SHALL provide parameter CNT_W, default 16, the width of the taken-redirect counter.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk in, rst in.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous reset, active low.
REQ-006 BranchE  input  1  execute-stage instruction is a conditional branch.
REQ-007 JumpE  input  1  execute-stage instruction is an unconditional jump.
REQ-008 BranchCondE  input  2  condition: 00 equal, 01 not-equal, 10 less-than, 11 greater-or-equal.
REQ-009 ZeroE  input  1  ALU zero flag.
REQ-010 NegE  input  1  ALU negative flag.
REQ-011 PCE  input  PC_W  PC of the execute-stage instruction.
REQ-012 ImmExtE  input  PC_W  sign-extended branch offset.
REQ-013 StallF  input  1  fetch stage cannot accept a redirect this cycle.
REQ-014 PCSrcE  output  1  redirect request to fetch, which loads PCTargetE.
REQ-015 PCTargetE  output  PC_W  redirect target.
REQ-016 FlushD  output  1  squash the decode-stage instruction.
REQ-017 FlushE  output  1  squash the execute-stage instruction.
REQ-018 TakenCount  output  CNT_W  number of accepted redirects.

Function
REQ-019 Taken SHALL be JumpE, or BranchE with the condition true: 00 ZeroE, 01 !ZeroE, 10 NegE, 11 !NegE.
REQ-020 JumpE SHALL take priority over BranchE when both are high.
REQ-021 The target SHALL be (PCE + ImmExtE) modulo 2^PC_W, with bits [1:0] forced to 00.
REQ-022 The FSM SHALL have exactly three states: IDLE, REDIRECT and SHADOW.
REQ-023 IDLE with Taken: the target SHALL be registered and the FSM SHALL enter REDIRECT on the next edge (1-cycle latency).
REQ-024 IDLE without Taken: the FSM SHALL stay in IDLE and all outputs except TakenCount SHALL be 0.
REQ-025 In REDIRECT, PCSrcE, FlushD and FlushE SHALL be 1, and PCTargetE SHALL hold the registered target.
REQ-026 REDIRECT with StallF=1: the state, PCSrcE and PCTargetE SHALL be held unchanged.
REQ-027 REDIRECT with StallF=0: the redirect is accepted and the FSM SHALL move to SHADOW.
REQ-028 In SHADOW (one cycle), PCSrcE SHALL be 0 and FlushD and FlushE SHALL be 0.
REQ-029 In SHADOW, BranchE and JumpE SHALL be ignored as wrong-path; the FSM SHALL then return to IDLE.
REQ-030 In REDIRECT, BranchE and JumpE SHALL be ignored; a second redirect never overwrites a pending target.
REQ-031 PCTargetE SHALL be 0 whenever PCSrcE is 0.
REQ-032 Target arithmetic SHALL wrap: PCE=0x1FC with ImmExtE=0x008 gives target 0x004.

Reset
REQ-033 Asserting rst low SHALL immediately force IDLE, with PCSrcE=0, PCTargetE=0, FlushD=0, FlushE=0 and TakenCount=0.
REQ-034 Reset during REDIRECT SHALL discard the pending target, with no acceptance counted.
REQ-035 After rst deasserts, a Taken sampled on the first edge SHALL be handled normally.

Configuration
REQ-036 Macro BRANCH_TAKEN_COUNT_EN SHALL control the redirect counter.
REQ-037 With BRANCH_TAKEN_COUNT_EN defined, TakenCount SHALL increment by 1 on each REDIRECT-to-SHADOW transition.
REQ-038 With BRANCH_TAKEN_COUNT_EN defined, TakenCount SHALL saturate at 2^CNT_W-1.
REQ-039 Without BRANCH_TAKEN_COUNT_EN, the port SHALL remain present, tied to 0, with no counter logic.

Verification
REQ-040 Bench SHALL drive JumpE=1, PCE=0x010, ImmExtE=0x020, StallF=0 -> next cycle PCSrcE=1, PCTargetE=0x030, FlushD=FlushE=1; following cycle PCSrcE=0.
REQ-041 Bench SHALL drive BranchE=1, BranchCondE=01, ZeroE=1 -> PCSrcE stays 0 for 3 cycles; with ZeroE=0 -> PCSrcE=1 next cycle.
REQ-042 Bench SHALL raise a redirect with StallF=1 for 3 cycles -> PCSrcE=1 and target constant for 3 cycles; the second JumpE with target 0x100 is ignored; StallF=0 then gives SHADOW.
REQ-043 Bench SHALL drive PCE=0x1FC, ImmExtE=0x008 -> PCTargetE=0x004; PCE=0x040, ImmExtE=0x1F0 (-16) -> PCTargetE=0x030.
REQ-044 Bench SHALL pulse rst low mid-REDIRECT -> all outputs 0 immediately, without waiting for clk; TakenCount unchanged by the aborted redirect.
REQ-045 Bench SHALL, with BRANCH_TAKEN_COUNT_EN and CNT_W=2, perform 5 accepted redirects -> TakenCount reads 1,2,3,3,3.

Source files
------------

// File: rtl/branch_redirect_unit.sv
// Branch redirect unit: resolves execute-stage branches/jumps, computes the
// aligned redirect target and sequences the fetch redirect through a small
// IDLE -> REDIRECT -> SHADOW FSM with decode/execute flushes.
// Optional feature: define BRANCH_TAKEN_COUNT_EN to enable the saturating
// count of accepted redirects on TakenCount; otherwise TakenCount is tied to 0.
module branch_redirect_unit #(
    parameter int unsigned PC_W  = 9,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             BranchE,
    input  logic             JumpE,
    input  logic [1:0]       BranchCondE,
    input  logic             ZeroE,
    input  logic             NegE,
    input  logic [PC_W-1:0]  PCE,
    input  logic [PC_W-1:0]  ImmExtE,
    input  logic             StallF,
    output logic             PCSrcE,
    output logic [PC_W-1:0]  PCTargetE,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] TakenCount
);

    typedef enum logic [1:0] {
        StIdle,
        StRedirect,
        StShadow
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] target_q, target_d;

    logic            cond_true;
    logic            taken;
    logic [PC_W-1:0] target_sum;
    logic [PC_W-1:0] target_calc;

    // Evaluate the branch condition from the ALU flags.
    always_comb begin
        cond_true = 1'b0;
        unique case (BranchCondE)
            2'b00:   cond_true = ZeroE;
            2'b01:   cond_true = ~ZeroE;
            2'b10:   cond_true = NegE;
            2'b11:   cond_true = ~NegE;
            default: cond_true = 1'b0;
        endcase
    end

    // A jump is always taken, so it dominates any simultaneous branch.
    assign taken = JumpE | (BranchE & cond_true);

    // Target wraps modulo 2^PC_W and is forced word aligned.
    assign target_sum  = PCE + ImmExtE;
    assign target_calc = {target_sum[PC_W-1:2], 2'b00};

    // Next-state and output decode; outputs are Moore so reset clears them at once.
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        PCSrcE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        PCTargetE = '0;
        case (state_q)
            StIdle: begin
                if (taken) begin
                    target_d = target_calc;
                    state_d  = StRedirect;
                end
            end
            StRedirect: begin
                // New branches here are wrong-path; the pending target is never replaced.
                PCSrcE    = 1'b1;
                FlushD    = 1'b1;
                FlushE    = 1'b1;
                PCTargetE = target_q;
                if (!StallF) begin
                    state_d = StShadow;
                end
            end
            StShadow: begin
                // The instruction in execute is wrong-path; ignore it for one cycle.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and pending-target registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

`ifdef BRANCH_TAKEN_COUNT_EN
    logic             accept;
    logic [CNT_W-1:0] count_q, count_d;

    // A redirect counts only when fetch actually takes it.
    assign accept = (state_q == StRedirect) && !StallF;

    // Saturating increment of the accepted-redirect count.
    always_comb begin
        count_d = count_q;
        if (accept && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign TakenCount = count_q;
`else
    assign TakenCount = '0;
`endif

endmodule
